// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO-to-stream reader.
// Optional feature macro: FIFO_READER_STATS_EN (adds the pkt_count output).
`timescale 1ns/1ps
`ifndef FIFO_READER_PKG_SV
`define FIFO_READER_PKG_SV

// One buffered beat: payload plus its end-of-packet marker.
`define FIFO_READER_BEAT_T(DW) struct packed { logic [(DW)-1:0] data; logic last; }

package fifo_reader_pkg;

  localparam int OCC_W = 2;

  localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
  localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
  localparam logic [OCC_W-1:0] OCC_FULL  = 2'd2;

  // Buffer occupancy after one cycle: a simultaneous load and pop cancel out.
  function automatic logic [OCC_W-1:0] occ_step(input logic [OCC_W-1:0] occ,
                                                 input logic load,
                                                 input logic pop);
    logic [OCC_W-1:0] nxt;
    nxt = occ;
    if (load && !pop && occ != OCC_FULL) begin
      nxt = occ + OCC_ONE;
    end else if (pop && !load && occ != OCC_EMPTY) begin
      nxt = occ - OCC_ONE;
    end
    return nxt;
  endfunction

endpackage

`endif

// File: rtl/fifo_reader_skid.sv
// Two-entry {data,last} buffer (main + skid) driving the stream master outputs.
// The main entry is the output register; the skid entry absorbs one beat on a stall.
`timescale 1ns/1ps
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  m_tready,
  output logic                  m_tvalid,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic [OCC_W-1:0]      occ
);

  typedef `FIFO_READER_BEAT_T(DATA_WIDTH) beat_t;

  beat_t            main_q, main_d;
  beat_t            skid_q, skid_d;
  beat_t            in_beat;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             pop;

  assign in_beat = {in_data, in_last};
  assign pop     = (occ_q != OCC_EMPTY) & m_tready;

  // Steer incoming beats into main or skid so output order always equals arrival order.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    occ_d  = occ_step(occ_q, load, pop);
    case (occ_q)
      OCC_EMPTY: begin
        if (load) begin
          main_d = in_beat;
        end
      end
      OCC_ONE: begin
        if (load && pop) begin
          main_d = in_beat;
        end else if (load) begin
          skid_d = in_beat;
        end
      end
      default: begin
        if (pop) begin
          main_d = skid_q;
          if (load) begin
            skid_d = in_beat;
          end
        end
      end
    endcase
  end

  // Buffer state registers; reset empties the buffer and clears the outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      occ_q  <= OCC_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign m_tvalid = (occ_q != OCC_EMPTY);
  assign m_tdata  = main_q.data;
  assign m_tlast  = main_q.last;
  assign occ      = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a sync FIFO (pull/empty port) into a valid/ready stream with tlast
// framing every pkt_len beats. fifo_pull depends only on registered occupancy
// and en, so there is no combinational path from m_tready or fifo_empty.
// Optional feature macro: FIFO_READER_STATS_EN adds the 32-bit pkt_count output.
`timescale 1ns/1ps
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  en,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_pull,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [31:0]           pkt_count
`endif
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  logic [OCC_W-1:0]     occ;
  logic                 load;
  logic                 beat_last;
  logic [LEN_WIDTH-1:0] cur_len;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  assign fifo_pull = en & (occ != OCC_FULL);
  assign load      = fifo_pull & ~fifo_empty;

  // Framing: the packet length is sampled on the first beat and held until the last one.
  always_comb begin
    cur_len = len_q;
    if (beat_cnt_q == '0) begin
      cur_len = (pkt_len == '0) ? LEN_ONE : pkt_len;
    end
    beat_last  = (beat_cnt_q == cur_len - LEN_ONE);
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    if (load) begin
      len_d      = cur_len;
      beat_cnt_d = beat_last ? '0 : beat_cnt_q + LEN_ONE;
    end
  end

  // Framing registers; reset drops any partial packet.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      len_q      <= LEN_ONE;
      beat_cnt_q <= '0;
    end else begin
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  fifo_reader_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .load     (load),
    .in_data  (fifo_data),
    .in_last  (beat_last),
    .m_tready (m_tready),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .occ      (occ)
  );

`ifdef FIFO_READER_STATS_EN
  logic [31:0] pkt_count_q;

  // Count packets as their last beat leaves the stream port; wraps naturally.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_count_q <= '0;
    end else if (m_tvalid && m_tready && m_tlast) begin
      pkt_count_q <= pkt_count_q + 32'd1;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule
